// File: rtl/imul_var_lat_param.sv
// Iterative zero-skipping multiplier: NBITS x NBITS -> 2*NBITS product, val/rdy on both sides.
// Latency: accept at cycle t, n CALC steps, out_val at t+n+1; one product per n+2 cycles back-to-back.
// Backpressure: in_rdy only in IDLE; the result is held in DONE until out_rdy. Signed mode needs IMUL_SIGNED_EN.
module imul_var_lat_param #(
  parameter int NBITS     = 32,
  parameter int SKIP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sd,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [NBITS-1:0]     in_msg_a,
  input  logic [NBITS-1:0]     in_msg_b,
  input  logic                 in_signed,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [2*NBITS-1:0]   out_msg
);

  localparam int PW = 2 * NBITS;
  localparam int ZW = $clog2(SKIP_BITS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PW-1:0]     a_reg;
  logic [NBITS-1:0]  b_reg;
  logic [PW-1:0]     result_reg;
  logic              neg_reg;

  logic [NBITS-1:0]  a_mag;
  logic [NBITS-1:0]  b_mag;
  logic              neg_in;
  logic [ZW-1:0]     z;
  logic              skip_all;
  logic [ZW-1:0]     shamt;
  logic [PW-1:0]     sum;
  logic [PW-1:0]     fin;
  logic [PW-1:0]     a_nxt;
  logic [NBITS-1:0]  b_nxt;
  logic              calc_done;

  // sd only labels the other ports; it carries no function inside the datapath.
  logic unused_ok;
  assign unused_ok = &{1'b0, sd, in_signed};

`ifdef IMUL_SIGNED_EN
  // Convert signed operands to magnitudes; the most negative value maps to 2^(NBITS-1).
  always_comb begin
    a_mag  = in_msg_a;
    b_mag  = in_msg_b;
    neg_in = 1'b0;
    if (in_signed) begin
      if (in_msg_a[NBITS-1]) a_mag = -in_msg_a;
      if (in_msg_b[NBITS-1]) b_mag = -in_msg_b;
      neg_in = in_msg_a[NBITS-1] ^ in_msg_b[NBITS-1];
    end
  end

  // Sign of the product, captured at accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       neg_reg <= 1'b0;
    else if (state == IDLE && in_val) neg_reg <= neg_in;
  end

  assign fin = neg_reg ? (~sum + PW'(1)) : sum;
`else
  assign a_mag   = in_msg_a;
  assign b_mag   = in_msg_b;
  assign neg_in  = 1'b0;
  assign neg_reg = neg_in;
  assign fin     = sum;
`endif

  // Trailing-zero count of the low window of b, saturating at SKIP_BITS.
  always_comb begin
    z = ZW'(SKIP_BITS);
    for (int i = SKIP_BITS - 1; i >= 0; i--) begin
      if (b_reg[i]) z = ZW'(i);
    end
  end

  assign skip_all  = (z == ZW'(SKIP_BITS));
  assign shamt     = skip_all ? ZW'(SKIP_BITS) : (z + ZW'(1));
  assign sum       = skip_all ? result_reg : (result_reg + (a_reg << z));
  assign a_nxt     = a_reg << shamt;
  assign b_nxt     = b_reg >> shamt;
  assign calc_done = (b_nxt == '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_val)    state_nxt = CALC;
      CALC:    if (calc_done) state_nxt = DONE;
      DONE:    if (out_rdy)   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Operand load at accept, then one shift/add step per CALC cycle; sign fix-up folds into the last step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_val) begin
            a_reg      <= PW'(a_mag);
            b_reg      <= b_mag;
            result_reg <= '0;
          end
        end
        CALC: begin
          a_reg      <= a_nxt;
          b_reg      <= b_nxt;
          result_reg <= calc_done ? fin : sum;
        end
        default: ;
      endcase
    end
  end

  assign in_rdy  = (state == IDLE);
  assign out_val = (state == DONE);
  assign out_msg = result_reg;

endmodule

// File: tb/tb_imul_var_lat_param.sv
module tb_imul_var_lat_param;

`ifdef IMUL_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sd = 1'b0;
  logic        in_val = 1'b0;
  logic        in_signed = 1'b0;
  logic        out_rdy = 1'b0;
  logic [31:0] in_msg_a = '0;
  logic [31:0] in_msg_b = '0;
  logic        in_rdy, out_val;
  logic [63:0] out_msg;

  logic        in_val1 = 1'b0;
  logic        out_rdy1 = 1'b0;
  logic        in_rdy1, out_val1;
  logic [63:0] out_msg1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imul_var_lat_param #(.NBITS(32), .SKIP_BITS(8)) dut (
    .clk(clk), .reset(reset), .sd(sd), .in_val(in_val), .in_rdy(in_rdy),
    .in_msg_a(in_msg_a), .in_msg_b(in_msg_b), .in_signed(in_signed),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg));

  imul_var_lat_param #(.NBITS(32), .SKIP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .sd(sd), .in_val(in_val1), .in_rdy(in_rdy1),
    .in_msg_a(in_msg_a), .in_msg_b(in_msg_b), .in_signed(in_signed),
    .out_val(out_val1), .out_rdy(out_rdy1), .out_msg(out_msg1));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b, input bit s);
    logic [63:0] ua, ub;
    longint      sa, sb;
    if (SEN && s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // Step count: walk the multiplier's bit positions; each step either jumps
  // a whole empty window or lands just past the next set bit within it.
  function automatic int model_steps(input logic [31:0] b, input bit s, input int S);
    logic [31:0] bm;
    int pos, steps;
    bit hit;
    bm = (SEN && s && b[31]) ? (~b + 32'd1) : b;
    pos = 0;
    steps = 0;
    do begin
      hit = 1'b0;
      for (int k = 0; k < S; k++)
        if (!hit && (pos + k) < 32 && bm[pos + k]) begin
          hit = 1'b1;
          pos = pos + k + 1;
        end
      if (!hit) pos = pos + S;
      steps++;
    end while (pos < 32 && (bm >> pos) != 32'd0);
    return steps;
  endfunction

  // Issue one request on the main DUT, collect the product and CALC cycle count.
  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input bit s,
                         output logic [63:0] prod, output int ncalc, output bit ok);
    int w;
    ok = 1'b1;
    w = 0;
    while (!in_rdy && w < 200) begin @(negedge clk); w++; end
    if (!in_rdy) ok = 1'b0;
    in_msg_a = a; in_msg_b = b; in_signed = s; in_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_val = 1'b0;
    in_msg_a = $urandom; in_msg_b = $urandom; in_signed = 1'($urandom);
    ncalc = 0;
    while (!out_val && ncalc < 200) begin ncalc++; @(negedge clk); end
    if (!out_val) ok = 1'b0;
    prod = out_msg;
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_rdy = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    logic [63:0] exp_en;
    logic [63:0] exp_dis;
    int          calc_en;
    int          calc_dis;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [63:0] prod, hold;
    int ncalc, w;
    bit ok;

    tbl[0] = '{"basic_3x5",   32'h3,        32'h5,        1'b0, 64'hF,                64'hF,                2, 2};
    tbl[1] = '{"neg3x7_s",    32'hFFFFFFFD, 32'h7,        1'b1, 64'hFFFFFFFFFFFFFFEB, 64'h00000006FFFFFFEB, 3, 3};
    tbl[2] = '{"neg3x7_u",    32'hFFFFFFFD, 32'h7,        1'b0, 64'h00000006FFFFFFEB, 64'h00000006FFFFFFEB, 3, 3};
    tbl[3] = '{"b_zero",      32'h1234,     32'h0,        1'b0, 64'h0,                64'h0,                1, 1};
    tbl[4] = '{"b_msb",       32'h1,        32'h80000000, 1'b0, 64'h80000000,         64'h80000000,         4, 4};
    tbl[5] = '{"ones_u",      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001, 32, 32};
    tbl[6] = '{"ones_s",      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1,                64'hFFFFFFFE00000001, 1, 32};
    tbl[7] = '{"minneg_s",    32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 64'h4000000000000000, 4, 4};
    tbl[8] = '{"six_x_seven", 32'h6,        32'h7,        1'b0, 64'd42,               64'd42,               3, 3};
    tbl[9] = '{"neg5x6_s",    32'hFFFFFFFB, 32'h6,        1'b1, 64'hFFFFFFFFFFFFFFE2, 64'h00000005FFFFFFE2, 2, 2};

    // Reset state.
    #1;
    check("rst_ctl", {62'b0, in_rdy, out_val}, 64'h2);
    check("rst_msg", out_msg, 64'h0);
    check("rst_ctl1", {62'b0, in_rdy1, out_val1}, 64'h2);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed vector table.
    foreach (tbl[i]) begin
      run_req(tbl[i].a, tbl[i].b, tbl[i].s, prod, ncalc, ok);
      check({tbl[i].name, "_done"}, 64'(ok), 64'h1);
      check({tbl[i].name, "_prod"}, prod, SEN ? tbl[i].exp_en : tbl[i].exp_dis);
      check({tbl[i].name, "_calc"}, 64'(ncalc), 64'(SEN ? tbl[i].calc_en : tbl[i].calc_dis));
    end

    // Randomized requests against the reference model.
    for (int r = 0; r < 40; r++) begin
      logic [31:0] ra, rb;
      bit rs;
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = rb & 32'h80100101;
        1: rb = rb & 32'h0000FFFF;
        2: rb = rb & 32'hF0000000;
        default: ;
      endcase
      run_req(ra, rb, rs, prod, ncalc, ok);
      check("rand_done", 64'(ok), 64'h1);
      check("rand_prod", prod, model_prod(ra, rb, rs));
      check("rand_calc", 64'(ncalc), 64'(model_steps(rb, rs, 8)));
    end

    // Backpressure: hold the result in DONE, then accept a new request on the return to IDLE.
    in_msg_a = 32'h3; in_msg_b = 32'h5; in_signed = 1'b0; in_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_val = 1'b0;
    w = 0;
    while (!out_val && w < 200) begin @(negedge clk); w++; end
    check("bp_reach_done", 64'(out_val), 64'h1);
    hold = out_msg;
    check("bp_first", hold, 64'hF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_ctl", {62'b0, out_val, in_rdy}, 64'h2);
      check("bp_msg", out_msg, 64'hF);
    end
    in_msg_a = 32'h6; in_msg_b = 32'h7; in_signed = 1'b0; in_val = 1'b1; out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_rdy = 1'b0;
    check("bp_idle", {62'b0, in_rdy, out_val}, 64'h2);
    @(posedge clk);
    @(negedge clk);
    in_val = 1'b0;
    check("bp_accepted", 64'(in_rdy), 64'h0);
    ncalc = 0;
    while (!out_val && ncalc < 200) begin ncalc++; @(negedge clk); end
    check("bp_next_calc", 64'(ncalc), 64'd3);
    check("bp_next_prod", out_msg, 64'd42);
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_rdy = 1'b0;

    // Reset in the middle of a calculation.
    in_msg_a = 32'h3; in_msg_b = 32'hFF; in_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_in_calc", {62'b0, in_rdy, out_val}, 64'h0);
    reset = 1'b1;
    #1;
    check("mid_rst_ctl", {62'b0, in_rdy, out_val}, 64'h2);
    check("mid_rst_msg", out_msg, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_req(32'h6, 32'h7, 1'b0, prod, ncalc, ok);
    check("post_rst_done", 64'(ok), 64'h1);
    check("post_rst_prod", prod, 64'd42);
    check("post_rst_calc", 64'(ncalc), 64'd3);

    // Single-bit skip window: one step per multiplier bit.
    in_msg_a = 32'h1; in_msg_b = 32'h80000000; in_signed = 1'b0; in_val1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_val1 = 1'b0;
    ncalc = 0;
    while (!out_val1 && ncalc < 200) begin ncalc++; @(negedge clk); end
    check("skip1_calc", 64'(ncalc), 64'd32);
    check("skip1_prod", out_msg1, 64'h80000000);
    out_rdy1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_rdy1 = 1'b0;
    check("skip1_idle", {62'b0, in_rdy1, out_val1}, 64'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imul_var_lat_param.md
Name: imul_var_lat_param

Overview:
- Parametrised, variable-latency iterative integer multiplier with val/rdy request and response interfaces.
- Successor to the fixed 32-bit zero-skipping multiplier. Adds configurable width, a configurable zero-skip window, a full 2*NBITS product and signed mode.
- Sits behind the processor's muldiv request queue. It consumes operand pairs and returns one product per request.

Parameters:
- NBITS, 32, operand width. Allowed range 4..64.
- SKIP_BITS, 8, maximum number of consecutive zero multiplier bits consumed per cycle. Must be a power of two, 1..NBITS.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sd  in  1  security-domain tag. clk, reset and sd are labelled L; every other port is labelled Domain sd.
- in_val  in  1  request valid.
- in_rdy  out  1  request ready.
- in_msg_a  in  NBITS  multiplicand.
- in_msg_b  in  NBITS  multiplier.
- in_signed  in  1  1 selects two's-complement operands; 0 selects unsigned operands.
- out_val  out  1  response valid.
- out_rdy  in  1  response ready.
- out_msg  out  2*NBITS  full product.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (asynchronous, any state, including mid-CALC): state goes to IDLE. a_reg, b_reg, result_reg, neg_reg are cleared. Outputs become in_rdy=1, out_val=0, out_msg=0.
- in_rdy=1 only in IDLE. out_val=1 only in DONE. out_msg = result_reg at all times.
- IDLE, on in_val=1:
  - result_reg <= 0.
  - If signed: a_reg <= zero-extended |a| (2*NBITS wide), b_reg <= |b|, neg_reg <= a[NBITS-1] ^ b[NBITS-1].
  - If unsigned: a_reg <= zero-extended a, b_reg <= b, neg_reg <= 0.
  - The most negative value's |x| is its unsigned magnitude 2^(NBITS-1).
  - Go to CALC.
- CALC, one step per cycle:
  - z = number of trailing zeros of b_reg[SKIP_BITS-1:0], saturating at SKIP_BITS.
  - If z == SKIP_BITS: b_reg >>= SKIP_BITS; a_reg <<= SKIP_BITS; no add.
  - Otherwise: result_reg += a_reg << z; b_reg >>= z+1; a_reg <<= z+1.
  - Shifts are logical. a_reg bits above 2*NBITS are discarded. The adder is 2*NBITS wide; carry out is discarded.
  - Go to DONE when the next b_reg == 0, else stay in CALC.
  - b == 0 at accept still takes exactly one CALC cycle.
- Entering DONE: if neg_reg, result_reg <= two's-complement negation of the final sum. The negation is applied on the CALC->DONE edge and adds no extra cycle.
- DONE: hold out_msg stable while out_rdy=0. On out_rdy=1, go to IDLE. No request is accepted in the same cycle.
- Latency: accept at cycle t, n CALC cycles, out_val=1 at cycle t+n+1.
  - n = number of steps; worst case NBITS when SKIP_BITS=1.
  - Back-to-back throughput: one product per n+2 cycles.
- in_signed, in_msg_a and in_msg_b are sampled only at accept. Changes during CALC or DONE are ignored.

Optional Feature:
- Macro: IMUL_SIGNED_EN.
- Defined: signed mode operates as described.
- Undefined: in_signed is ignored and treated as 0. The abs/negate logic is not built, and neg_reg is tied to 0. Product is always unsigned. Port list is unchanged.

Test Plan:
- Basic unsigned, NBITS=32, SKIP_BITS=8: a=3, b=5, unsigned -> 2 CALC cycles; out_val 3 cycles after accept; out_msg=0x000000000000000F.
- Signed (IMUL_SIGNED_EN defined): a=0xFFFFFFFD (-3), b=7, in_signed=1 -> 3 CALC cycles; out_msg=0xFFFFFFFFFFFFFFEB. Same operands with in_signed=0 -> out_msg=0x00000006FFFFFFEB. Same operands, macro undefined, in_signed=1 -> unsigned result.
- Zero/skip boundaries:
  - b=0, a=0x1234 -> 1 CALC cycle; out_msg=0.
  - b=0x80000000, a=1 -> 4 CALC cycles (3 full skips plus 1 add); out_msg=0x0000000080000000.
  - Repeat b=0x80000000 with SKIP_BITS=1 -> 32 CALC cycles.
- Extremes: a=b=0xFFFFFFFF, unsigned -> out_msg=0xFFFFFFFE00000001. Same operands, signed -> out_msg=1. a=b=0x80000000, signed -> out_msg=0x4000000000000000.
- Backpressure: hold out_rdy=0 for 5 cycles in DONE -> out_val=1, out_msg stable, in_rdy=0 throughout. Raise out_rdy -> IDLE next cycle, in_rdy=1. A new request with in_val held high is accepted on that cycle.
- Mid-operation reset: assert reset during the 2nd CALC cycle of a=3, b=0xFF -> immediately in_rdy=1, out_val=0, out_msg=0. A following request a=6, b=7 -> out_msg=42 with normal latency.
